// File: rtl/ca_code_gen_if.sv
// Control/replica bundle for the C/A Gold-code generator.
// master drives load/tick; slave (the generator) drives the chips and status.
interface ca_code_gen_if;
  logic       prn_load;
  logic [5:0] prn_id;
  logic       half_tick;
  logic       early_chip;
  logic       prompt_chip;
  logic       late_chip;
  logic [9:0] chip_cnt;
  logic       epoch;
  logic       running;
  logic       prn_err;

  modport master (
    output prn_load,
    output prn_id,
    output half_tick,
    input  early_chip,
    input  prompt_chip,
    input  late_chip,
    input  chip_cnt,
    input  epoch,
    input  running,
    input  prn_err
  );

  modport slave (
    input  prn_load,
    input  prn_id,
    input  half_tick,
    output early_chip,
    output prompt_chip,
    output late_chip,
    output chip_cnt,
    output epoch,
    output running,
    output prn_err
  );
endinterface

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator with early/prompt/late replicas
// spaced half a chip apart, advanced by DLL half-chip strobes.
module ca_code_gen #(
  parameter int CODE_LEN = 1023
) (
  input logic          CLK,
  input logic          RST,
  ca_code_gen_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'(CODE_LEN - 1);
  localparam logic [9:0] ONES    = '1;

  state_t     state;
  state_t     state_nx;
  logic [9:0] g1;
  logic [9:0] g2;
  logic [9:0] tap;
  logic [9:0] cnt;
  logic       phase;
  logic       prompt;
  logic       late;
  logic       epoch;
  logic       err;
  logic       early;

  logic       id_ok;
  logic       ld_ok;
  logic       ld_bad;
  logic       adv;
  logic       wrap;
  logic       g1_fb;
  logic       g2_fb;

  // Bit k-1 of the mask selects G2 stage k.
  function automatic logic [9:0] sel(int a, int b);
    return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
  endfunction

  function automatic logic [9:0] tap_mask(logic [5:0] id);
    logic [9:0] m;
    m = '0;
    case (id)
      6'd1:    m = sel(2, 6);
      6'd2:    m = sel(3, 7);
      6'd3:    m = sel(4, 8);
      6'd4:    m = sel(5, 9);
      6'd5:    m = sel(1, 9);
      6'd6:    m = sel(2, 10);
      6'd7:    m = sel(1, 8);
      6'd8:    m = sel(2, 9);
      6'd9:    m = sel(3, 10);
      6'd10:   m = sel(2, 3);
      6'd11:   m = sel(3, 4);
      6'd12:   m = sel(5, 6);
      6'd13:   m = sel(6, 7);
      6'd14:   m = sel(7, 8);
      6'd15:   m = sel(8, 9);
      6'd16:   m = sel(9, 10);
      6'd17:   m = sel(1, 4);
      6'd18:   m = sel(2, 5);
      6'd19:   m = sel(3, 6);
      6'd20:   m = sel(4, 7);
      6'd21:   m = sel(5, 8);
      6'd22:   m = sel(6, 9);
      6'd23:   m = sel(1, 3);
      6'd24:   m = sel(4, 6);
      6'd25:   m = sel(5, 7);
      6'd26:   m = sel(6, 8);
      6'd27:   m = sel(7, 9);
      6'd28:   m = sel(8, 10);
      6'd29:   m = sel(1, 6);
      6'd30:   m = sel(2, 7);
      6'd31:   m = sel(3, 8);
      6'd32:   m = sel(4, 9);
      default: m = '0;
    endcase
    return m;
  endfunction

  assign id_ok  = (bus.prn_id != 6'd0) && (bus.prn_id <= 6'd32);
  assign ld_ok  = bus.prn_load && id_ok;
  assign ld_bad = bus.prn_load && !id_ok;
  assign adv    = bus.half_tick && (state == RUN) && !bus.prn_load;
  assign wrap   = adv && phase && (cnt == CNT_MAX);

  // Stage k lives in bit k-1; feedback enters stage 1.
  assign g1_fb = g1[2] ^ g1[9];
  assign g2_fb = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
  assign early = g1[9] ^ (^(g2 & tap));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      ld_ok:   state_nx = RUN;
      ld_bad:  state_nx = IDLE;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      g1     <= '0;
      g2     <= '0;
      tap    <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      prompt <= 1'b0;
      late   <= 1'b0;
      epoch  <= 1'b0;
      err    <= 1'b0;
    end else if (ld_ok) begin
      g1     <= ONES;
      g2     <= ONES;
      tap    <= tap_mask(bus.prn_id);
      cnt    <= '0;
      phase  <= 1'b0;
      prompt <= 1'b0;
      late   <= 1'b0;
      epoch  <= 1'b0;
      err    <= 1'b0;
    end else if (ld_bad) begin
      g1     <= '0;
      g2     <= '0;
      tap    <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
      prompt <= 1'b0;
      late   <= 1'b0;
      epoch  <= 1'b0;
      err    <= 1'b1;
    end else begin
      epoch <= 1'b0;
      if (adv) begin
        prompt <= early;
        late   <= prompt;
        phase  <= ~phase;
        // Restore on wrap so short CODE_LEN still gives an exact period.
        if (wrap) begin
          cnt   <= '0;
          g1    <= ONES;
          g2    <= ONES;
          epoch <= 1'b1;
        end else if (phase) begin
          cnt <= cnt + 10'd1;
          g1  <= {g1[8:0], g1_fb};
          g2  <= {g2[8:0], g2_fb};
        end
      end
    end
  end

  assign bus.early_chip  = early;
  assign bus.prompt_chip = prompt;
  assign bus.late_chip   = late;
  assign bus.chip_cnt    = cnt;
  assign bus.epoch       = epoch;
  assign bus.running     = (state == RUN);
  assign bus.prn_err     = err;

endmodule

// File: tb/tb_ca_code_gen.sv
// Bench for ca_code_gen: directed steps plus random loads/ticks,
// checked against a chip-table model indexed by half-ticks since load.
module tb_ca_code_gen;

  logic clk;
  logic rst;

  ca_code_gen_if bus ();

  ca_code_gen dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  int ta_t[32] = '{2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9,
                   1, 2, 3, 4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4};
  int tb_t[32] = '{6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10,
                   4, 5, 6, 7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9};

  bit ca[1:32][0:1022];

  bit m_run;
  bit m_err;
  bit m_ep;
  int m_prn;
  int m_t;

  int n_ep;

  task automatic build_table();
    int g1[1:10];
    int g2[1:10];
    int f1;
    int f2;
    for (int p = 1; p <= 32; p++) begin
      for (int k = 1; k <= 10; k++) begin
        g1[k] = 1;
        g2[k] = 1;
      end
      for (int i = 0; i < 1023; i++) begin
        ca[p][i] = bit'(g1[10] ^ g2[ta_t[p-1]] ^ g2[tb_t[p-1]]);
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        for (int k = 10; k >= 2; k--) begin
          g1[k] = g1[k-1];
          g2[k] = g2[k-1];
        end
        g1[1] = f1;
        g2[1] = f2;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic e, p, l, ep, run;
    logic [9:0] c;
    if (!m_run) begin
      e = 0; p = 0; l = 0; c = 0; ep = 0; run = 0;
    end else begin
      run = 1;
      c   = 10'((m_t / 2) % 1023);
      e   = ca[m_prn][(m_t / 2) % 1023];
      p   = (m_t >= 1) ? ca[m_prn][((m_t - 1) / 2) % 1023] : 1'b0;
      l   = (m_t >= 2) ? ca[m_prn][((m_t - 2) / 2) % 1023] : 1'b0;
      ep  = m_ep;
    end
    chk({tag, ".early"}, 32'(bus.early_chip), 32'(e));
    chk({tag, ".prompt"}, 32'(bus.prompt_chip), 32'(p));
    chk({tag, ".late"}, 32'(bus.late_chip), 32'(l));
    chk({tag, ".cnt"}, 32'(bus.chip_cnt), 32'(c));
    chk({tag, ".epoch"}, 32'(bus.epoch), 32'(ep));
    chk({tag, ".running"}, 32'(bus.running), 32'(run));
    chk({tag, ".prn_err"}, 32'(bus.prn_err), 32'(m_err));
  endtask

  task automatic cyc(string tag, bit r, bit ld, int id, bit tk);
    rst           = r;
    bus.prn_load  = ld;
    bus.prn_id    = 6'(id);
    bus.half_tick = tk;
    @(posedge clk);
    if (!r) begin
      m_run = 0; m_err = 0; m_t = 0; m_ep = 0;
    end else if (ld) begin
      m_ep = 0;
      m_t  = 0;
      if (id >= 1 && id <= 32) begin
        m_run = 1; m_err = 0; m_prn = id;
      end else begin
        m_run = 0; m_err = 1;
      end
    end else if (tk && m_run) begin
      m_t++;
      m_ep = (m_t % 2046 == 0);
    end else begin
      m_ep = 0;
    end
    #1;
    check_all(tag);
    if (bus.epoch === 1'b1) n_ep++;
  endtask

  initial begin
    logic [9:0] seq;
    bit p1[0:2045];
    int diffs;
    n_cmp = 0;
    n_bad = 0;
    n_ep  = 0;
    m_run = 0; m_err = 0; m_ep = 0; m_prn = 1; m_t = 0;
    build_table();

    for (int i = 0; i < 3; i++) cyc("reset", 0, 0, 0, bit'(i % 2));
    cyc("idle", 1, 0, 0, 1);

    cyc("load1", 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) seq[9 - k/2] = bus.early_chip;
      cyc("prn1", 1, 0, 0, 1);
    end
    chk("prn1_seq", 32'(seq), 32'(10'o1440));

    cyc("load2", 1, 1, 2, 0);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) seq[9 - k/2] = bus.early_chip;
      cyc("prn2", 1, 0, 0, 1);
    end
    chk("prn2_seq", 32'(seq), 32'(10'o1620));
    for (int k = 0; k < 7; k++) cyc("prn2b", 1, 0, 0, 1);
    cyc("load32", 1, 1, 32, 1);
    chk("reload_cnt", 32'(bus.chip_cnt), 32'd0);
    chk("reload_early", 32'(bus.early_chip), 32'd1);

    cyc("load7", 1, 1, 7, 0);
    n_ep = 0;
    for (int k = 0; k < 2046; k++) begin
      p1[k] = bus.early_chip;
      cyc("prn7a", 1, 0, 0, 1);
    end
    chk("epoch_count1", 32'(n_ep), 32'd1);
    chk("epoch_cnt0", 32'(bus.chip_cnt), 32'd0);
    diffs = 0;
    for (int k = 0; k < 2046; k++) begin
      if (bus.early_chip !== p1[k]) diffs++;
      cyc("prn7b", 1, 0, 0, 1);
    end
    chk("repeat_diffs", 32'(diffs), 32'd0);
    chk("epoch_count2", 32'(n_ep), 32'd2);

    cyc("bad0", 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc("bad0t", 1, 0, 0, 1);
    cyc("bad40", 1, 1, 40, 0);
    for (int k = 0; k < 4; k++) cyc("bad40t", 1, 0, 0, 1);
    chk("bad_err", 32'(bus.prn_err), 32'd1);
    chk("bad_run", 32'(bus.running), 32'd0);
    cyc("load5", 1, 1, 5, 0);
    chk("err_clr", 32'(bus.prn_err), 32'd0);

    cyc("collide", 1, 1, 3, 1);
    cyc("coll_t1", 1, 0, 0, 1);
    chk("coll_cnt1", 32'(bus.chip_cnt), 32'd0);
    cyc("coll_t2", 1, 0, 0, 1);
    chk("coll_cnt2", 32'(bus.chip_cnt), 32'd1);

    cyc("load9", 1, 1, 9, 0);
    for (int k = 0; k < 1000; k++) cyc("run9", 1, 0, 0, 1);
    chk("chip500", 32'(bus.chip_cnt), 32'd500);
    cyc("run9x", 1, 0, 0, 1);
    cyc("rst_run", 0, 0, 0, 1);
    cyc("post_rst", 1, 0, 0, 1);

    for (int k = 0; k < 3000; k++) begin
      bit r, ld, tk;
      int id;
      r  = ($urandom_range(0, 499) != 0);
      ld = ($urandom_range(0, 79) == 0);
      tk = bit'($urandom_range(0, 1));
      id = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 32))
                                       : int'($urandom_range(0, 63));
      cyc("rand", r, ld, id, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
# ca_code_gen

GPS L1 C/A Gold-code generator for the early/late tracking channel. It runs the IS-GPS-200 G1/G2 LFSR pair for a selected satellite and produces early, prompt and late replica chips, spaced half a chip apart. Chips advance on half-chip strobes from the DLL NCO. The early and late chips drive the PRN inputs of the early and late correlator XOR stages; the epoch pulse frames the summation blocks.

## Interface
- `CODE_LEN`, default 1023: chips per code period; chip counter wraps at `CODE_LEN-1`.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: synchronous, active-low reset.
- `prn_load` in 1: one-cycle strobe; latch `prn_id` and restart the code.
- `prn_id` in 6: satellite PRN number; valid values are 1..32.
- `half_tick` in 1: one-cycle strobe from the NCO at each half-chip boundary.
- `early_chip` out 1: current generator output (1 = chip '1').
- `prompt_chip` out 1: early delayed by one half-chip.
- `late_chip` out 1: early delayed by two half-chips (E–L spacing = 1 chip).
- `chip_cnt` out 10: index of the chip currently on `early_chip`, 0..`CODE_LEN-1`.
- `epoch` out 1: one-cycle pulse when `chip_cnt` wraps to 0.
- `running` out 1: high in RUN state.
- `prn_err` out 1: sticky; set by a load with an invalid `prn_id`.

## Operation
- **States:** IDLE and RUN. Reset enters IDLE.
- **G1 register:** 10-bit LFSR, polynomial 1+x³+x¹⁰; feedback is s3^s10, shifted into stage 1.
- **G2 register:** 10-bit LFSR, polynomial 1+x²+x³+x⁶+x⁸+x⁹+x¹⁰; feedback is s2^s3^s6^s8^s9^s10.
- **Chip value:** `early_chip` = G1.s10 ^ G2.s(ta) ^ G2.s(tb).
  - The tap pair (ta,tb) is the IS-GPS-200 Table 3-Ia phase-selector pair for the latched PRN, e.g. PRN1 (2,6), PRN2 (3,7), PRN23 (1,3), PRN32 (4,9).
  - All 32 pairs are held in a constant lookup.
  - Taps are registered at load, never decoded live from `prn_id`.
- **Valid load** (`prn_load`=1, `prn_id` 1..32), in either state:
  - G1 and G2 set to all ones; `chip_cnt` = 0; half-phase bit = 0; delay line = 00.
  - Taps latched; `prn_err` cleared; state goes to RUN.
- **Invalid load** (`prn_id` 0 or 33..63):
  - State goes to IDLE; `prn_err` set.
  - Generator registers are cleared to the reset values.
- **`half_tick` in RUN:**
  - Delay line shifts: prompt ← early, late ← prompt.
  - Half-phase toggles.
  - When half-phase was 1, both LFSRs step once and `chip_cnt` increments.
  - At `CODE_LEN-1` the increment wraps `chip_cnt` to 0, pulses `epoch`, and restores G1/G2 to all ones, so the period is exact even if `CODE_LEN` ≠ 1023.
- **`half_tick` in IDLE:** ignored.
- **Load and `half_tick` in the same cycle:** load wins; the tick is discarded.

## Timing
- **Reset values:** all outputs 0; state IDLE; G1, G2 and taps cleared.
- **`running`:** goes high the cycle after a valid load.
- **`early_chip` after load:** is the chip-0 value the cycle after the load.
  - For every PRN this is 1, because all stages are 1.
  - Chip 0 lasts two `half_tick`s.
- **Output timing:** `early_chip` is combinational from registered state. `prompt_chip` and `late_chip` are registered and update the cycle after a `half_tick`.
- **`epoch`:** registered; high for exactly the one cycle following the `half_tick` that wraps `chip_cnt`.
- **`half_tick` spacing:** back-to-back ticks (every cycle) are legal; each tick advances exactly one half-chip.
- **Reset during RUN:** takes effect on the next edge. No partial code state survives.
- **`prn_err`:** changes only on a load or on reset.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles with `half_tick` toggling → all outputs 0, `running`=0, `chip_cnt`=0.
- **PRN1 sequence:** load `prn_id`=1, then 20 `half_tick`s → `early_chip` over chips 0..9 = 1100100000 (octal 1440). `prompt_chip` equals the same sequence delayed one tick; `late_chip` is delayed two ticks.
- **PRN2 and PRN32:**
  - Load 2 → first 10 chips 1110010000 (octal 1620).
  - Reload 32 mid-run → `chip_cnt` returns to 0 and `early_chip`=1 on the next cycle.
- **Epoch:** PRN7 run for 2046 `half_tick`s → single `epoch` pulse and `chip_cnt`=0. After the next 2046 ticks, the sequence repeats bit-exactly with a second pulse.
- **Invalid PRN:**
  - Load `prn_id`=0, then 40 → `prn_err`=1, `running`=0, ticks ignored.
  - A valid load of 5 clears `prn_err`.
- **Collision and reset:**
  - Assert `prn_load` and `half_tick` together → tick discarded; chip 0 still needs two further ticks.
  - Assert `RST`=0 during chip 500 → all outputs 0 on the next cycle.
